// File: rtl/spi_reg_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_pkg
//   Shared constants and types for the SPI register peripheral.
//   - Register address map for the five PWM control registers.
//   - Frame geometry: 16-bit frames, MSB first, R/W flag in bit 15.
//   - Bit-counter width and saturation value used to flag overlong frames.
//   - FSM state type (IDLE while nCS is high, SHIFT while it is low).
// ---------------------------------------------------------------------------
package spi_reg_pkg;

   localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

   localparam int FRAME_BITS = 16;
   localparam int RW_BIT     = 15;

   localparam int         CNT_W   = 5;
   localparam logic [4:0] CNT_FULL = 5'd16;
   // Any frame that reaches this count is overlong; the counter parks here.
   localparam logic [4:0] CNT_SAT  = 5'd17;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/spi_reg_peripheral_input_synchronizer.sv
// ---------------------------------------------------------------------------
// input_synchronizer
//   Multi-flop synchroniser bringing a single asynchronous bit into the clk
//   domain.
//   Ports:
//     clk   - system clock
//     rst_n - synchronous active-low reset, loads RST_VAL into every stage
//     d_i   - asynchronous input bit
//     q_o   - synchronised output (last stage)
//   Parameters:
//     SYNC_STAGES - number of flops in the chain (>= 2)
//     RST_VAL     - value every stage takes on reset
// ---------------------------------------------------------------------------
module input_synchronizer #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_peripheral.sv
// ---------------------------------------------------------------------------
// spi_reg_peripheral
//   Write-only SPI mode-0 target. Receives 16-bit frames (R/W, 7-bit address,
//   8-bit data, MSB first) and updates the five PWM control registers.
//   SCLK is oversampled in the clk domain; it never clocks any flop.
//   Ports:
//     clk             - system clock
//     rst_n           - synchronous active-low reset
//     sclk, copi, ncs - asynchronous SPI pins (ncs active-low)
//     en_reg_out_7_0  - register 0x00
//     en_reg_out_15_8 - register 0x01
//     en_reg_pwm_7_0  - register 0x02
//     en_reg_pwm_15_8 - register 0x03
//     pwm_duty_cycle  - register 0x04
//     frame_err       - one-cycle pulse when a frame has the wrong bit count
// ---------------------------------------------------------------------------
module spi_reg_peripheral
   import spi_reg_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       frame_err
);

   logic sclk_s, copi_s, ncs_s;

   input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s));
   input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .d_i(copi), .q_o(copi_s));
   input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .d_i(ncs), .q_o(ncs_s));

   logic                   sclk_prev_q, ncs_prev_q;
   logic [SYNC_STAGES-1:0] flush_q;
   logic                   armed_q, armed_d;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [FRAME_BITS-1:0]  shift_q, shift_d;
   logic                   err_q, err_d;
   logic [7:0]             out_lo_q, out_lo_d, out_hi_q, out_hi_d;
   logic [7:0]             pwm_lo_q, pwm_lo_d, pwm_hi_q, pwm_hi_d;
   logic [7:0]             duty_q, duty_d;

   logic       sclk_rise, ncs_rise, ncs_fall;
   logic       frame_ok, wr_en;
   logic [6:0] frame_addr;
   logic [7:0] frame_data;

   // After reset the ncs chain holds its reset value (high) until real
   // samples reach the end. If ncs is physically low at that point the
   // apparent high-to-low transition is an artefact, not a frame start.
   // flush_q marks when the chain carries only post-reset samples, and
   // armed_q is set once a genuine high has been seen; falling edges are
   // accepted only after that, so a frame cut by reset is never resumed.
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign ncs_rise  = ncs_s & ~ncs_prev_q;
   assign ncs_fall  = ~ncs_s & ncs_prev_q & armed_q;
   assign armed_d   = armed_q | (flush_q[SYNC_STAGES-1] & ncs_s);

   assign frame_addr = shift_q[RW_BIT-1:8];
   assign frame_data = shift_q[7:0];
   assign frame_ok   = (cnt_q == CNT_FULL);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_prev_q <= 1'b0;
         ncs_prev_q  <= 1'b1;
         flush_q     <= '0;
         armed_q     <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         err_q       <= 1'b0;
         out_lo_q    <= 8'h00;
         out_hi_q    <= 8'h00;
         pwm_lo_q    <= 8'h00;
         pwm_hi_q    <= 8'h00;
         duty_q      <= 8'h00;
      end else begin
         sclk_prev_q <= sclk_s;
         ncs_prev_q  <= ncs_s;
         flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
         armed_q     <= armed_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         err_q       <= err_d;
         out_lo_q    <= out_lo_d;
         out_hi_q    <= out_hi_d;
         pwm_lo_q    <= pwm_lo_d;
         pwm_hi_q    <= pwm_hi_d;
         duty_q      <= duty_d;
      end
   end

   // Next-state: ncs edges take priority over a coincident sclk edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      err_d   = 1'b0;
      wr_en   = 1'b0;

      if (ncs_fall) begin
         state_d = ST_SHIFT;
         cnt_d   = '0;
         shift_d = '0;
      end else if (state_q == ST_SHIFT) begin
         if (ncs_rise) begin
            state_d = ST_IDLE;
            wr_en   = frame_ok & shift_q[RW_BIT] & (frame_addr <= MAX_ADDR);
            err_d   = ~frame_ok;
         end else if (sclk_rise) begin
            shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
            if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + 5'd1;
            end
         end
      end
   end

   // Register file: only the addressed register changes on a commit.
   always_comb begin
      out_lo_d = out_lo_q;
      out_hi_d = out_hi_q;
      pwm_lo_d = pwm_lo_q;
      pwm_hi_d = pwm_hi_q;
      duty_d   = duty_q;
      if (wr_en) begin
         case (frame_addr)
            ADDR_EN_OUT_7_0:  out_lo_d = frame_data;
            ADDR_EN_OUT_15_8: out_hi_d = frame_data;
            ADDR_EN_PWM_7_0:  pwm_lo_d = frame_data;
            ADDR_EN_PWM_15_8: pwm_hi_d = frame_data;
            ADDR_PWM_DUTY:    duty_d   = frame_data;
            default: ;
         endcase
      end
   end

   assign en_reg_out_7_0  = out_lo_q;
   assign en_reg_out_15_8 = out_hi_q;
   assign en_reg_pwm_7_0  = pwm_lo_q;
   assign en_reg_pwm_15_8 = pwm_hi_q;
   assign pwm_duty_cycle  = duty_q;
   assign frame_err       = err_q;

endmodule
